// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int DCACHE_INDEX_BITS = 3;
    localparam int DCACHE_ADDR_WIDTH = 32;
    localparam int DCACHE_DATA_WIDTH = 32;
    localparam int DCACHE_TAG_BITS   = DCACHE_ADDR_WIDTH - DCACHE_INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        RESP
    } state_e;

    typedef struct packed {
        logic                         valid;
        logic [DCACHE_TAG_BITS-1:0]   tag;
        logic [DCACHE_DATA_WIDTH-1:0] data;
    } line_t;

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the data cache: asynchronous read by index, one synchronous line write.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = DCACHE_INDEX_BITS,
    parameter int TAG_BITS   = DCACHE_TAG_BITS,
    parameter int DATA_WIDTH = DCACHE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_all,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_arr  [LINES];
    logic [DATA_WIDTH-1:0] data_arr [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_arr[rd_index];
    assign rd_data  = data_arr[rd_index];

    // Only the valid bits carry reset; tag/data contents are don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clear_all) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_arr[wr_index]  <= wr_tag;
            data_arr[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller with a single-word req/ack memory port.
module dcache_refill_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = DCACHE_INDEX_BITS,
    parameter int ADDR_WIDTH = DCACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH = DCACHE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    state_e                state;
    logic [DATA_WIDTH-1:0] resp_data;

    logic [INDEX_BITS-1:0] lookup_index;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic                  line_valid;
    logic [TAG_BITS-1:0]   line_tag;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  hit;
    logic                  arr_we;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic                  flush_clr;
    logic                  addr_lsb_unused;

    assign addr_lsb_unused = ^cpu_addr[1:0];

    // While a transaction is open the latched memory address names the line, not the live CPU address.
    always_comb begin
        if (state == IDLE) begin
            lookup_index = cpu_addr[INDEX_BITS+1:2];
            lookup_tag   = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
        end else begin
            lookup_index = mem_addr[INDEX_BITS+1:2];
            lookup_tag   = mem_addr[ADDR_WIDTH-1:INDEX_BITS+2];
        end
    end

    assign hit       = line_valid && (line_tag == lookup_tag);
    assign flush_clr = flush && (state == IDLE);
    // A store that hits rewrites the same tag with valid already set, so one write port covers both cases.
    assign arr_we    = mem_ack && ((state == REFILL) || ((state == WRITE) && hit));
    assign arr_wdata = (state == REFILL) ? mem_rdata : mem_wdata;

    dcache_line_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lines (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_all(flush_clr),
        .rd_index (lookup_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_we),
        .wr_index (mem_addr[INDEX_BITS+1:2]),
        .wr_tag   (mem_addr[ADDR_WIDTH-1:INDEX_BITS+2]),
        .wr_data  (arr_wdata)
    );

    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (flush || cpu_we || !hit) begin
                        cpu_stall = 1'b1;
                    end else begin
                        cpu_rdata = line_data;
                    end
                end
            end
            REFILL, WRITE: cpu_stall = 1'b1;
            RESP: begin
                if (cpu_req && !cpu_we) begin
                    cpu_rdata = resp_data;
                end
            end
            default: cpu_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            resp_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req && !flush) begin
                        if (cpu_we) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata <= cpu_wdata;
                            state     <= WRITE;
                        end else if (!hit) begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                            state    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        resp_data <= mem_rdata;
                        mem_req   <= 1'b0;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Scoreboard bench for dcache_refill_ctrl: directed accesses push expected responses, monitors pop and compare.
module tb_dcache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        flush = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata = '0;

    logic mdl_ack  = 1'b0;
    logic spur_ack = 1'b0;
    assign mem_ack = mdl_ack | spur_ack;

    always #5 clk = ~clk;

    dcache_refill_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .flush    (flush),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        int          stall;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memtx_t;

    resp_t       resp_q[$];
    memtx_t      mem_q[$];
    int          checks = 0;
    int          errors = 0;
    int          lat = 3;
    int          lat_cnt = 0;
    logic [31:0] mdl [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: acks lat cycles after the first cycle mem_req is seen.
    always @(negedge clk) begin
        if (!rst_n) begin
            lat_cnt = 0;
            mdl_ack = 1'b0;
        end else if (mem_req && !mdl_ack) begin
            lat_cnt++;
            if (lat_cnt == lat + 1) begin
                mdl_ack = 1'b1;
                lat_cnt = 0;
                if (mem_we) begin
                    mdl[mem_addr] = mem_wdata;
                    mem_rdata = 32'h0;
                end else begin
                    mem_rdata = mdl.exists(mem_addr) ? mdl[mem_addr] : 32'h0;
                end
            end
        end else begin
            mdl_ack = 1'b0;
        end
    end

    int   stall_cnt = 0;
    logic prev_req  = 1'b0;

    always @(negedge clk) begin
        memtx_t t;
        resp_t  r;
        if (!rst_n) begin
            stall_cnt = 0;
            prev_req  = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                if (mem_q.size() == 0) begin
                    check("mem_txn_expected", 32'(mem_q.size()), 32'd1);
                end else begin
                    t = mem_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(t.we));
                    check("mem_addr", mem_addr, t.addr);
                    if (t.we) check("mem_wdata", mem_wdata, t.wdata);
                end
            end
            prev_req = mem_req;
            if (cpu_req && cpu_stall) begin
                stall_cnt++;
            end else if (cpu_req) begin
                if (resp_q.size() == 0) begin
                    check("resp_expected", 32'(resp_q.size()), 32'd1);
                end else begin
                    r = resp_q.pop_front();
                    check("cpu_rdata", cpu_rdata, r.rdata);
                    check("stall_cycles", 32'(stall_cnt), 32'(r.stall));
                end
                stall_cnt = 0;
            end
            if (!cpu_req || cpu_stall) check("rdata_not_resp", cpu_rdata, 32'h0);
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_stall,
                          input logic expect_mem, input logic with_flush);
        int n;
        n = 0;
        if (expect_mem) mem_q.push_back(memtx_t'{we, addr & ~32'h3, wdata});
        resp_q.push_back(resp_t'{(we ? 32'h0 : exp_rdata), exp_stall});
        @(posedge clk); #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        flush     = with_flush;
        if (with_flush) begin
            @(posedge clk); #1;
            flush = 1'b0;
        end
        do begin
            @(negedge clk);
            n++;
        end while (cpu_stall && n < 50);
        if (cpu_stall) check("stall_timeout", 32'(cpu_stall), 32'h0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    initial begin
        mdl[32'h10] = 32'hDEADBEEF;
        mdl[32'h30] = 32'h12345678;
        mdl[32'h44] = 32'h00000000;

        #12;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 5, 1'b1, 1'b0);   // cold miss
        access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0);   // hit
        @(posedge clk); #1 spur_ack = 1'b1;
        @(posedge clk); #1 spur_ack = 1'b0;
        access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0);   // stray ack ignored
        access(1'b0, 32'h30, 32'h0, 32'h12345678, 5, 1'b1, 1'b0);   // same index, new tag
        access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 5, 1'b1, 1'b0);   // evicted
        access(1'b0, 32'h30, 32'h0, 32'h12345678, 5, 1'b1, 1'b0);
        access(1'b1, 32'h30, 32'hA5A5A5A5, 32'h0, 5, 1'b1, 1'b0);   // store hit
        access(1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 0, 1'b0, 1'b0);   // hit with stored data
        access(1'b1, 32'h44, 32'hCAFEF00D, 32'h0, 5, 1'b1, 1'b0);   // store miss
        lat = 1;
        access(1'b0, 32'h44, 32'h0, 32'hCAFEF00D, 3, 1'b1, 1'b0);   // no-write-allocate
        lat = 3;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        access(1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 5, 1'b1, 1'b0);   // miss after flush
        access(1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 6, 1'b1, 1'b1);   // flush wins over hit

        // Reset in the middle of a refill of index 4.
        mem_q.push_back(memtx_t'{1'b0, 32'h10, 32'h0});
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h10;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'h0);
        check("async_rst_mem_addr", mem_addr, 32'h0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        access(1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 5, 1'b1, 1'b0);   // line 4 invalid after reset

        repeat (5) @(posedge clk);
        check("resp_q_drained", 32'(resp_q.size()), 32'h0);
        check("mem_q_drained", 32'(mem_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
